stack_transfer_sequencer: RTL and testbench

- Multi-cycle sequencer for CALL/RET/INT/RTI stack traffic.
- On a start request it pushes or pops a PC that may be wider than the memory word, plus an optional flags word. It drives the data-memory port one word per granted cycle and stalls the pipeline until the transfer completes.
- Sits between the memory stage and data memory, and owns the stack pointer.

---
 rtl/stack_transfer_sequencer_if.sv | 28 ++
 rtl/stack_transfer_sequencer.sv | 172 +++++++++++++++++
 tb/tb_stack_transfer_sequencer.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stack_transfer_sequencer_if.sv
// Data-memory port between the stack transfer sequencer and data memory.
//
// Handshake: the sequencer raises exactly one of Mem_Read / Mem_Write with
// Mem_Addr (and Mem_Data_Out for writes) and holds them stable. The memory
// answers with Mem_Gnt. A word moves at a rising edge only when a request
// and Mem_Gnt are both high. Read data returns on Mem_Data_In during the
// cycle after the accepting edge.
interface stack_transfer_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 11
);
  logic [ADDR_W-1:0] Mem_Addr;
  logic [DATA_W-1:0] Mem_Data_Out;
  logic              Mem_Read;
  logic              Mem_Write;
  logic              Mem_Gnt;
  logic [DATA_W-1:0] Mem_Data_In;

  modport master (
    output Mem_Addr, Mem_Data_Out, Mem_Read, Mem_Write,
    input  Mem_Gnt, Mem_Data_In
  );

  modport slave (
    input  Mem_Addr, Mem_Data_Out, Mem_Read, Mem_Write,
    output Mem_Gnt, Mem_Data_In
  );
endinterface

// File: rtl/stack_transfer_sequencer.sv
// Stack transfer sequencer for CALL/RET/INT/RTI.
// Pushes or pops a multi-word PC plus an optional flags word through the
// data-memory port, one word per granted cycle, and owns the stack pointer.
// One buffer holds the words of the transfer: slots 0..PC_WORDS-1 are the
// PC words (LSW first), slot PC_WORDS is the zero-extended flags word. A push
// loads it from the inputs; a pop fills it from read data.
module stack_transfer_sequencer #(
  parameter int DATA_W   = 16,
  parameter int PC_WORDS = 2,
  parameter int FLAG_W   = 4,
  parameter int ADDR_W   = 11,
  parameter logic [ADDR_W-1:0] SP_INIT = '1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         Start,
  input  logic                         Push,
  input  logic                         With_Flags,
  input  logic [PC_WORDS*DATA_W-1:0]   PC_In,
  input  logic [FLAG_W-1:0]            Flags_In,
  stack_transfer_sequencer_if.master   mem,
  output logic                         Stall_Signal,
  output logic                         Busy,
  output logic                         Done,
  output logic [PC_WORDS*DATA_W-1:0]   PC_Out,
  output logic [FLAG_W-1:0]            Flags_Out,
  output logic [ADDR_W-1:0]            SP,
  output logic                         Sp_Wrap,
  output logic [1:0]                   state_dbg
);

  localparam int PC_W  = PC_WORDS * DATA_W;
  localparam int BUF_W = (PC_WORDS + 1) * DATA_W;
  localparam int KW    = $clog2(PC_WORDS + 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state;
  logic [KW-1:0]     k;
  logic              push_q;
  logic              flags_q;
  logic [BUF_W-1:0]  buf_q;
  logic              rd_pend;
  logic [KW-1:0]     rd_slot;
  logic              wrap_q;

  logic [KW-1:0]     slot;
  logic [KW-1:0]     k_last;
  logic [ADDR_W-1:0] sp_step;
  logic              step_wrap;
  logic [BUF_W-1:0]  merged;

  assign Busy         = (state != IDLE);
  assign Stall_Signal = ((state == IDLE) && Start) || Busy;
  assign state_dbg    = state;

  // Index of the last word of this transfer (N-1).
  assign k_last = KW'(PC_WORDS - 1) + KW'(flags_q);

  // Next SP for the current word and whether that step wraps.
  assign sp_step   = push_q ? (SP - ADDR_W'(1)) : (SP + ADDR_W'(1));
  assign step_wrap = push_q ? (SP == '0) : (SP == '1);

  // Buffer slot addressed by word counter k: push is MSW..LSW then flags,
  // pop is the exact reverse so flags come off the top first.
  always_comb begin
    slot = '0;
    if (push_q) begin
      if (k < KW'(PC_WORDS)) slot = KW'(PC_WORDS - 1) - k;
      else                   slot = KW'(PC_WORDS);
    end else if (flags_q) begin
      if (k == '0) slot = KW'(PC_WORDS);
      else         slot = k - KW'(1);
    end else begin
      slot = k;
    end
  end

  // Buffer with the read word arriving this cycle folded in, so DRAIN can
  // publish every word in one edge.
  always_comb begin
    merged = buf_q;
    if (rd_pend) merged[rd_slot*DATA_W +: DATA_W] = mem.Mem_Data_In;
  end

  // Memory request outputs: Moore function of state, k and SP.
  always_comb begin
    mem.Mem_Addr     = '0;
    mem.Mem_Data_Out = '0;
    mem.Mem_Read     = 1'b0;
    mem.Mem_Write    = 1'b0;
    if (state == XFER) begin
      if (push_q) begin
        mem.Mem_Write    = 1'b1;
        mem.Mem_Addr     = SP;
        mem.Mem_Data_Out = buf_q[slot*DATA_W +: DATA_W];
      end else begin
        mem.Mem_Read = 1'b1;
        mem.Mem_Addr = SP + ADDR_W'(1);
      end
    end
  end

  // Sequencer FSM with SP, word counter, read capture and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      k         <= '0;
      push_q    <= 1'b0;
      flags_q   <= 1'b0;
      buf_q     <= '0;
      rd_pend   <= 1'b0;
      rd_slot   <= '0;
      wrap_q    <= 1'b0;
      SP        <= SP_INIT;
      Done      <= 1'b0;
      Sp_Wrap   <= 1'b0;
      PC_Out    <= '0;
      Flags_Out <= '0;
    end else begin
      Done    <= 1'b0;
      Sp_Wrap <= 1'b0;
      rd_pend <= 1'b0;
      buf_q   <= merged;
      case (state)
        IDLE: begin
          if (Start) begin
            push_q  <= Push;
            flags_q <= With_Flags;
            buf_q   <= {DATA_W'(Flags_In), PC_In};
            k       <= '0;
            wrap_q  <= 1'b0;
            state   <= XFER;
          end
        end
        XFER: begin
          if (mem.Mem_Gnt) begin
            SP     <= sp_step;
            k      <= k + KW'(1);
            wrap_q <= wrap_q | step_wrap;
            if (!push_q) begin
              rd_pend <= 1'b1;
              rd_slot <= slot;
            end
            if (k == k_last) begin
              if (push_q) begin
                state   <= IDLE;
                Done    <= 1'b1;
                Sp_Wrap <= wrap_q | step_wrap;
              end else begin
                state <= DRAIN;
              end
            end
          end
        end
        DRAIN: begin
          PC_Out <= merged[PC_W-1:0];
          if (flags_q) Flags_Out <= merged[PC_W +: FLAG_W];
          Done    <= 1'b1;
          Sp_Wrap <= wrap_q;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_transfer_sequencer.sv
// Self-checking bench for stack_transfer_sequencer: directed cases plus
// randomized push/pop traffic against an address/word-level stack model.
module tb_stack_transfer_sequencer;

  localparam int DW = 16;
  localparam int PW = 2;
  localparam int FW = 4;
  localparam int AW = 11;
  localparam int DEPTH = 2048;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              start, push, with_flags;
  logic [PW*DW-1:0]  pc_in;
  logic [FW-1:0]     flags_in;
  logic              stall, busy, done, sp_wrap;
  logic [PW*DW-1:0]  pc_out;
  logic [FW-1:0]     flags_out;
  logic [AW-1:0]     sp;
  logic [1:0]        state_dbg;

  stack_transfer_sequencer_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  stack_transfer_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .Start        (start),
    .Push         (push),
    .With_Flags   (with_flags),
    .PC_In        (pc_in),
    .Flags_In     (flags_in),
    .mem          (bus),
    .Stall_Signal (stall),
    .Busy         (busy),
    .Done         (done),
    .PC_Out       (pc_out),
    .Flags_Out    (flags_out),
    .SP           (sp),
    .Sp_Wrap      (sp_wrap),
    .state_dbg    (state_dbg)
  );

  // memory seen by the DUT, and the model's own image of the stack
  logic [DW-1:0] bus_mem [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  int            ref_sp;
  logic [PW*DW-1:0] ref_pc_out;
  logic [FW-1:0]    ref_flags_out;

  // scoreboard: expected memory ops {is_write, addr, data}
  logic [1+AW+DW-1:0] exp_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    start = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ref_sp = DEPTH - 1;
    ref_pc_out = '0;
    ref_flags_out = '0;
    check("rst_sp", sp, 11'h7FF);
    check("rst_busy", busy, 0);
    check("rst_stall", stall, 0);
    check("rst_done", done, 0);
    check("rst_wrap", sp_wrap, 0);
    check("rst_rd", bus.Mem_Read, 0);
    check("rst_wr", bus.Mem_Write, 0);
    check("rst_addr", bus.Mem_Addr, 0);
    check("rst_wdata", bus.Mem_Data_Out, 0);
    check("rst_pc", pc_out, 0);
    check("rst_flags", flags_out, 0);
  endtask

  task automatic idle(input int cycles);
    start = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check("idle_done", done, 0);
      check("idle_busy", busy, 0);
      check("idle_stall", stall, 0);
      check("idle_sp", sp, ref_sp);
      check("idle_req", {bus.Mem_Read, bus.Mem_Write}, 0);
    end
  endtask

  // One transfer; entered and left at a falling edge. Returns in the Done cycle.
  // gmode: 0 grant always, 1 random grant, 2 grant withheld 3 cycles on word 2.
  task automatic run_xfer(input bit p, input bit wf, input logic [PW*DW-1:0] pc,
                          input logic [FW-1:0] fl, input int gmode);
    int n, a, c, lows, acc, start_sp, exp_lat, base;
    bit wrap_exp, rd_pend, got_done, g, held;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] w;
    logic [DW-1:0] rd_words [PW+1];
    logic [1+AW+DW-1:0] obs, held_obs;

    n = PW + int'(wf);
    start_sp = ref_sp;
    exp_q.delete();
    if (p) begin
      for (int i = 0; i < n; i++) begin
        w = (i < PW) ? pc[(PW-1-i)*DW +: DW] : DW'(fl);
        a = (start_sp - i + DEPTH) % DEPTH;
        exp_q.push_back({1'b1, AW'(a), w});
        ref_mem[a] = w;
      end
      wrap_exp = (start_sp - n) < 0;
      ref_sp = (start_sp - n + DEPTH) % DEPTH;
      exp_lat = n + 1;
    end else begin
      for (int i = 0; i < n; i++) begin
        a = (start_sp + 1 + i) % DEPTH;
        exp_q.push_back({1'b0, AW'(a), DW'(0)});
        rd_words[i] = ref_mem[a];
      end
      base = wf ? 1 : 0;
      if (wf) ref_flags_out = rd_words[0][FW-1:0];
      for (int j = 0; j < PW; j++) ref_pc_out[j*DW +: DW] = rd_words[base+j];
      wrap_exp = (start_sp + n) > (DEPTH - 1);
      ref_sp = (start_sp + n) % DEPTH;
      exp_lat = n + 2;
    end

    start = 1'b1; push = p; with_flags = wf; pc_in = pc; flags_in = fl;
    bus.Mem_Gnt = 1'($urandom_range(0, 1));
    #1 check("stall_start", stall, 1);

    c = 0; lows = 0; acc = 0; rd_pend = 0; got_done = 0; held = 0; held_obs = '0;
    while (c < 60) begin
      @(negedge clk);
      c++;
      if (rd_pend) bus.Mem_Data_In = bus_mem[rd_addr];
      else         bus.Mem_Data_In = DW'($urandom);
      rd_pend = 0;
      if (done) begin
        got_done = 1;
        break;
      end
      check("stall_busy", stall, 1);
      check("busy", busy, 1);
      check("wrap_mid", sp_wrap, 0);
      check("sp_track", sp, p ? (start_sp - acc + DEPTH) % DEPTH : (start_sp + acc) % DEPTH);
      // Start while busy must be ignored
      start = ($urandom_range(0, 3) == 0);
      push = 1'($urandom); with_flags = 1'($urandom);
      pc_in = PW*DW'($urandom); flags_in = FW'($urandom);
      if (bus.Mem_Read || bus.Mem_Write) begin
        check("rw_excl", bus.Mem_Read && bus.Mem_Write, 0);
        obs = {bus.Mem_Write, bus.Mem_Addr, bus.Mem_Write ? bus.Mem_Data_Out : DW'(0)};
        if (held) check("hold_req", obs, held_obs);
        case (gmode)
          0:       g = 1;
          1:       g = ($urandom_range(0, 3) != 0);
          default: g = !(acc == 1 && lows < 3);
        endcase
        bus.Mem_Gnt = g;
        if (g) begin
          held = 0;
          if (exp_q.size() == 0) check("extra_op", 1, 0);
          else check("mem_op", obs, exp_q.pop_front());
          if (bus.Mem_Write) bus_mem[bus.Mem_Addr] = bus.Mem_Data_Out;
          else begin
            rd_pend = 1;
            rd_addr = bus.Mem_Addr;
          end
          acc++;
        end else begin
          held = 1;
          held_obs = obs;
          lows++;
        end
      end else begin
        held = 0;
        bus.Mem_Gnt = 1'($urandom_range(0, 1));
      end
    end

    check("done_seen", got_done, 1);
    check("latency", c, exp_lat + lows);
    check("ops_left", exp_q.size(), 0);
    check("sp_end", sp, ref_sp);
    check("sp_wrap", sp_wrap, wrap_exp);
    check("busy_done", busy, 0);
    check("stall_done", stall, start);
    check("req_done", {bus.Mem_Read, bus.Mem_Write}, 0);
    check("pc_out", pc_out, ref_pc_out);
    check("flags_out", flags_out, ref_flags_out);
  endtask

  task automatic reset_mid_pop();
    start = 1'b1; push = 1'b0; with_flags = 1'b1;
    bus.Mem_Gnt = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("rmp_busy", busy, 1);
    check("rmp_second", bus.Mem_Read, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ref_sp = DEPTH - 1; ref_pc_out = '0; ref_flags_out = '0;
    check("rmp_idle", busy, 0);
    check("rmp_sp", sp, 11'h7FF);
    check("rmp_done", done, 0);
    check("rmp_pc", pc_out, 0);
    check("rmp_flags", flags_out, 0);
    check("rmp_req", {bus.Mem_Read, bus.Mem_Write}, 0);
    @(negedge clk);
    check("rmp_no_done", done, 0);
    check("rmp_no_req", {bus.Mem_Read, bus.Mem_Write}, 0);
  endtask

  initial begin
    bit p, wf;
    start = 0; push = 0; with_flags = 0; pc_in = '0; flags_in = '0;
    bus.Mem_Gnt = 1'b0; bus.Mem_Data_In = '0;
    for (int i = 0; i < DEPTH; i++) begin
      bus_mem[i] = DW'($urandom);
      ref_mem[i] = bus_mem[i];
    end

    do_reset();

    // push with flags, then pop back-to-back
    run_xfer(1, 1, 32'h0001_2345, 4'h5, 0);
    check("tp_push_sp", sp, 11'h7FC);
    check("tp_m7ff", bus_mem[11'h7FF], 16'h0001);
    check("tp_m7fe", bus_mem[11'h7FE], 16'h2345);
    check("tp_m7fd", bus_mem[11'h7FD], 16'h0005);
    run_xfer(0, 1, '0, '0, 0);
    check("tp_pop_pc", pc_out, 32'h0001_2345);
    check("tp_pop_flags", flags_out, 4'h5);
    check("tp_pop_sp", sp, 11'h7FF);
    idle(2);

    // grant withheld on the second word
    run_xfer(1, 1, PW*DW'($urandom), FW'($urandom), 2);
    idle(1);
    run_xfer(0, 1, '0, '0, 2);
    idle(1);

    // random traffic
    for (int i = 0; i < 150; i++) begin
      p = 1'($urandom); wf = 1'($urandom);
      run_xfer(p, wf, PW*DW'($urandom), FW'($urandom), 1);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(1);

    // walk SP down to 0, then push across the wrap
    do_reset();
    for (int i = 0; i < 681; i++) run_xfer(1, 1, PW*DW'($urandom), FW'($urandom), 0);
    for (int i = 0; i < 2; i++) run_xfer(1, 0, PW*DW'($urandom), FW'($urandom), 0);
    idle(1);
    check("fill_sp0", sp, 11'h000);
    run_xfer(1, 0, 32'hAAAA_5555, 4'h0, 0);
    check("wrap_push_sp", sp, 11'h7FE);
    check("wrap_push_pulse", sp_wrap, 1);
    check("wrap_push_done", done, 1);
    check("wrap_m000", bus_mem[11'h000], 16'hAAAA);
    check("wrap_m7ff", bus_mem[11'h7FF], 16'h5555);
    idle(1);
    check("wrap_pulse_once", sp_wrap, 0);
    run_xfer(0, 0, '0, '0, 1);
    check("wrap_pop_pc", pc_out, 32'hAAAA_5555);
    idle(1);

    reset_mid_pop();
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
